// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//
// UART transmit serializer. Takes a parallel byte on a one-cycle start
// strobe and shifts out a frame on `tx`: one start bit (low), DBIT data
// bits LSB first, then a stop bit (high). Bit timing advances only on
// cycles where the 16x-baud enable `s_tick` is high; `s_tick` is never
// used as a clock.
//
// Parameters:
//   DBIT    - data bits per frame (5..8)
//   SB_TICK - stop-bit length in s_tick units (16 = 1, 24 = 1.5, 32 = 2)
//   OS_TICK - s_tick pulses per start bit and per data bit
//
// Ports:
//   clk          in  system clock, rising-edge active
//   reset        in  asynchronous active-high reset
//   s_tick       in  16x-baud enable pulse
//   tx_start     in  one-cycle request to send din
//   din          in  byte to send; bits [DBIT-1:0] are used
//   tx           out serial line, idles high, registered
//   tx_busy      out high from frame acceptance until return to IDLE
//   tx_done_tick out one-cycle pulse when the stop bit completes
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int OS_TICK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       tx_start,
  input  logic [7:0] din,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done_tick
);

  // The tick counter must hold the larger of the per-bit and stop-bit
  // terminal counts; with the defaults this is 4 bits.
  localparam int TICK_MAX = (SB_TICK > OS_TICK) ? SB_TICK : OS_TICK;
  localparam int TW       = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

  localparam logic [TW-1:0] OS_LAST  = TW'(OS_TICK - 1);
  localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
  localparam logic [2:0]    BIT_LAST = 3'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state;
  logic [TW-1:0]   tick_cnt;
  logic [2:0]      bit_cnt;
  logic [DBIT-1:0] shreg;

  // NOTE: tx is assigned explicitly on every transition, to the value the
  // line must carry in the new state, so it comes straight off a flop and
  // can never glitch on decode logic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      tx           <= 1'b1;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; the default below is
      // overridden later in the same block only on the completion edge,
      // which gives a single-cycle pulse without any extra logic.
      tx_done_tick <= 1'b0;

      case (state)
        IDLE: begin
          tx <= 1'b1;
          // A tick coincident with acceptance is deliberately not counted:
          // the counter is cleared here instead of advanced.
          if (tx_start) begin
            shreg    <= din[DBIT-1:0];
            tick_cnt <= '0;
            tx_busy  <= 1'b1;
            tx       <= 1'b0;
            state    <= START;
          end
        end

        START: begin
          if (s_tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              tx       <= shreg[0];
              state    <= DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        DATA: begin
          if (s_tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt <= '0;
              shreg    <= shreg >> 1;
              if (bit_cnt == BIT_LAST) begin
                tx    <= 1'b1;
                state <= STOP;
              end else begin
                // Next data bit is the one about to land in shreg[0].
                bit_cnt <= bit_cnt + 3'd1;
                tx      <= shreg[1];
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        STOP: begin
          tx <= 1'b1;
          if (s_tick) begin
            if (tick_cnt == SB_LAST) begin
              tick_cnt     <= '0;
              tx_busy      <= 1'b0;
              tx_done_tick <= 1'b1;
              state        <= IDLE;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        default: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
